sm_hex_scan_display: RTL and testbench

Parametrised multiplexed hex display controller for the board tops. It shows one page of a 32-bit debug word, typically `regData` from `sm_top`, on a common-strobe 7-segment bank of `DIGITS` digits. A debounced push-button steps through the pages. It also provides optional leading-zero blanking and a sticky "value changed" decimal point. It replaces per-digit static `sm_hex_display` wiring in board tops whose boards have more digits than pins allow, or that need to see all 32 bits.

---
 rtl/sm_hex_scan_display_pkg.sv | 54 +++++
 rtl/sm_hex_scan_display_debounce.sv | 54 +++++
 rtl/sm_hex_scan_display.sv | 128 ++++++++++++
 tb/tb_sm_hex_scan_display.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_hex_scan_display_pkg.sv
// Shared constants for the scanned hex display: active-low glyphs {a,b,c,d,e,f,g},
// the blank pattern and the derived page-index width.
package sm_hex_scan_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h01;
  localparam logic [6:0] GLYPH_1 = 7'h4F;
  localparam logic [6:0] GLYPH_2 = 7'h12;
  localparam logic [6:0] GLYPH_3 = 7'h06;
  localparam logic [6:0] GLYPH_4 = 7'h4C;
  localparam logic [6:0] GLYPH_5 = 7'h24;
  localparam logic [6:0] GLYPH_6 = 7'h20;
  localparam logic [6:0] GLYPH_7 = 7'h0F;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h04;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h60;
  localparam logic [6:0] GLYPH_C = 7'h31;
  localparam logic [6:0] GLYPH_D = 7'h42;
  localparam logic [6:0] GLYPH_E = 7'h30;
  localparam logic [6:0] GLYPH_F = 7'h38;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // Pages of a 32-bit word for a given digit count; at least one index bit.
  function automatic int page_width(input int digits);
    int np;
    np = 8 / digits;
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/sm_hex_scan_display_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a raw board switch.
// out follows the synchronised input once it has differed for DEBOUNCE cycles; rise pulses on 0->1.
module sm_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clkIn,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;

  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    rise_d = 1'b0;
    if (sync2_q != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d  = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;

endmodule

// File: rtl/sm_hex_scan_display.sv
// Multiplexed hex display: shows one page of a 32-bit word on DIGITS strobed digits,
// with button paging, leading-zero blanking and a sticky value-changed decimal point.
module sm_hex_scan_display
  import sm_hex_scan_display_pkg::*;
#(
  parameter int  DIGITS   = 2,
  parameter int  SCAN_DIV = 50000,
  parameter int  DEBOUNCE = 500000,
  localparam int PAGE_W   = page_width(DIGITS)
) (
  input  logic              clkIn,
  input  logic              rst_n,
  input  logic [31:0]       value,
  input  logic              pageBtn,
  input  logic              blankZero,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] digitSel,
  output logic [PAGE_W-1:0] page
);

  localparam int NPAGES = 8 / DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tc_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [31:0]       shadow_q, shadow_d;
  logic              flag_q, flag_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  logic btn_level, btn_rise;
  logic tc, wrap, adv;
  logic [3:0] nib;
  logic       upper_nonzero;
  logic       blank;
  int         base;

  sm_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clkIn (clkIn),
    .rst_n (rst_n),
    .in    (pageBtn),
    .out   (btn_level),
    .rise  (btn_rise)
  );

  assign tc   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign wrap = tc && (idx_q == IDX_W'(DIGITS - 1));
  assign adv  = btn_rise && btn_level;

  always_comb begin
    div_d    = tc ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    page_d   = page_q;
    shadow_d = shadow_q;
    flag_d   = flag_q;
    if (tc && DIGITS > 1) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    if (wrap) begin
      shadow_d = value;
    end
    if (adv) begin
      page_d = (page_q == PAGE_W'(NPAGES - 1)) ? '0 : page_q + 1'b1;
      flag_d = 1'b0;
    end
    // A change captured in the same cycle as a page advance keeps the flag set.
    if (wrap && (value != shadow_q)) begin
      flag_d = 1'b1;
    end
  end

  always_comb begin
    base          = int'(page_q) * DIGITS;
    nib           = 4'(shadow_q >> (4 * (base + int'(idx_q))));
    upper_nonzero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(idx_q) && (4'(shadow_q >> (4 * (base + k))) != 4'h0)) begin
        upper_nonzero = 1'b1;
      end
    end
    blank = blankZero && (idx_q != '0) && !upper_nonzero;

    seg_d = seg_q;
    dp_d  = dp_q;
    sel_d = sel_q;
    // Outputs reload the cycle after terminal count, once idx/shadow have settled.
    if (tc_q) begin
      seg_d = blank ? SEG_BLANK : hex_glyph(nib);
      dp_d  = !(flag_q && (idx_q == '0));
      sel_d = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      tc_q     <= 1'b0;
      idx_q    <= '0;
      page_q   <= '0;
      shadow_q <= '0;
      flag_q   <= 1'b0;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
      sel_q    <= '1;
    end else begin
      div_q    <= div_d;
      tc_q     <= tc;
      idx_q    <= idx_d;
      page_q   <= page_d;
      shadow_q <= shadow_d;
      flag_q   <= flag_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      sel_q    <= sel_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign digitSel = sel_q;
  assign page     = page_q;

endmodule

// File: tb/tb_sm_hex_scan_display.sv
// Directed bench for sm_hex_scan_display: a 2-digit and an 8-digit instance share
// clock, reset, button and blanking inputs; expected glyphs come from a local table.
module tb_sm_hex_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic        blank_zero;
  logic [31:0] value2, value8;
  logic [6:0]  seg2, seg8;
  logic        dp2, dp8;
  logic [1:0]  sel2;
  logic [7:0]  sel8;
  logic [1:0]  page2;
  logic [0:0]  page8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Clock and reset-relative cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  sm_hex_scan_display #(.DIGITS(2), .SCAN_DIV(4), .DEBOUNCE(8)) dut2 (
    .clkIn     (clk),
    .rst_n     (rst_n),
    .value     (value2),
    .pageBtn   (btn),
    .blankZero (blank_zero),
    .seg       (seg2),
    .dp        (dp2),
    .digitSel  (sel2),
    .page      (page2)
  );

  sm_hex_scan_display #(.DIGITS(8), .SCAN_DIV(4), .DEBOUNCE(8)) dut8 (
    .clkIn     (clk),
    .rst_n     (rst_n),
    .value     (value8),
    .pageBtn   (btn),
    .blankZero (blank_zero),
    .seg       (seg8),
    .dp        (dp8),
    .digitSel  (sel8),
    .page      (page8)
  );

  // Driver tasks and checker.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    btn = 1'b1;
    step(16);
    btn = 1'b0;
    step(16);
  endtask

  task automatic wait_sel2(input int d);
    logic [1:0] exp;
    exp = ~(2'b01 << d);
    for (int i = 0; i < 40; i++) begin
      if (sel2 == exp) break;
      @(negedge clk);
    end
    chk($sformatf("sel2_d%0d", d), 32'(sel2), 32'(exp));
  endtask

  task automatic wait_sel8(input int d);
    logic [7:0] exp;
    exp = ~(8'h01 << d);
    for (int i = 0; i < 40; i++) begin
      if (sel8 == exp) break;
      @(negedge clk);
    end
    chk($sformatf("sel8_d%0d", d), 32'(sel8), 32'(exp));
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 16; i++) begin
      if (cyc % 8 == ph) break;
      @(negedge clk);
    end
    chk("phase", 32'(cyc % 8), 32'(ph));
  endtask

  logic [31:0] pv;
  logic [31:0] dv;

  initial begin
    rst_n      = 1'b0;
    btn        = 1'b0;
    blank_zero = 1'b0;
    value2     = 32'h0000_00A5;
    value8     = 32'hDEAD_BEEF;
    pv         = 32'h1234_5678;
    dv         = 32'hDEAD_BEEF;

    // Reset state and first strobes.
    step(3);
    chk("rst_seg", 32'(seg2), 32'h7F);
    chk("rst_dp", 32'(dp2), 32'h1);
    chk("rst_sel", 32'(sel2), 32'h3);
    chk("rst_page", 32'(page2), 32'h0);
    chk("rst_sel8", 32'(sel8), 32'hFF);
    rst_n = 1'b1;
    step(4);
    chk("dark_4", 32'(sel2), 32'h3);
    step(1);
    chk("first_sel", 32'(sel2), 32'h1);
    step(4);
    chk("f1_sel0", 32'(sel2), 32'h2);
    chk("f1_seg0", 32'(seg2), 32'(glyph[5]));
    chk("f1_dp0", 32'(dp2), 32'h0);
    step(4);
    chk("f1_sel1", 32'(sel2), 32'h1);
    chk("f1_seg1", 32'(seg2), 32'(glyph[10]));
    chk("f1_dp1", 32'(dp2), 32'h1);

    // Paging through 0x12345678.
    value2 = pv;
    step(16);
    for (int p = 1; p <= 4; p++) begin
      press();
      chk($sformatf("page_%0d", p), 32'(page2), 32'(p % 4));
      wait_sel2(0);
      chk($sformatf("pg%0d_seg0", p), 32'(seg2), 32'(glyph[pv[8*(p%4) +: 4]]));
      if (p == 1) chk("pg1_dp_clr", 32'(dp2), 32'h1);
      wait_sel2(1);
      chk($sformatf("pg%0d_seg1", p), 32'(seg2), 32'(glyph[pv[8*(p%4)+4 +: 4]]));
    end
    chk("page8_fixed", 32'(page8), 32'h0);

    // Bounce rejection: one advance, 11 cycles after the last edge.
    for (int i = 0; i < 12; i++) begin
      btn = ~btn;
      step(3);
    end
    btn = 1'b1;
    step(10);
    chk("bounce_early", 32'(page2), 32'h0);
    step(1);
    chk("bounce_adv", 32'(page2), 32'h1);
    btn = 1'b0;
    step(20);
    chk("bounce_once", 32'(page2), 32'h1);

    // Leading-zero blanking on page 0.
    press();
    press();
    press();
    chk("blank_page0", 32'(page2), 32'h0);
    blank_zero = 1'b1;
    value2     = 32'h0000_0003;
    step(20);
    wait_sel2(1);
    chk("blank_d1", 32'(seg2), 32'h7F);
    wait_sel2(0);
    chk("blank_d0_3", 32'(seg2), 32'(glyph[3]));
    value2 = 32'h0;
    step(20);
    wait_sel2(0);
    chk("blank_d0_0", 32'(seg2), 32'(glyph[0]));
    wait_sel2(1);
    chk("blank_d1_0", 32'(seg2), 32'h7F);
    blank_zero = 1'b0;
    step(8);
    wait_sel2(1);
    chk("noblank_d1", 32'(seg2), 32'(glyph[0]));

    // Tear-free capture and change flag.
    value2 = 32'h1111_1111;
    step(24);
    press();
    wait_sel2(0);
    chk("flag_clr", 32'(dp2), 32'h1);
    wait_phase(3);
    value2 = 32'h2222_2222;
    wait_sel2(1);
    chk("tear_old_d1", 32'(seg2), 32'(glyph[1]));
    wait_sel2(0);
    chk("tear_new_d0", 32'(seg2), 32'(glyph[2]));
    chk("flag_set", 32'(dp2), 32'h0);
    wait_sel2(1);
    chk("tear_new_d1", 32'(seg2), 32'(glyph[2]));
    press();
    wait_sel2(0);
    chk("flag_clr2", 32'(dp2), 32'h1);

    // Press advance lands on the same edge as a differing capture.
    wait_phase(5);
    btn = 1'b1;
    step(4);
    value2 = 32'h1111_1111;
    step(8);
    chk("coin_page", 32'(page2), 32'h3);
    chk("coin_sel", 32'(sel2), 32'h2);
    chk("coin_dp", 32'(dp2), 32'h0);
    btn = 1'b0;
    step(16);

    // Eight-digit instance: single page, glyphs DEADBEEF.
    chk("page8_stay", 32'(page8), 32'h0);
    for (int d = 0; d < 8; d++) begin
      wait_sel8(d);
      chk($sformatf("d8_glyph%0d", d), 32'(seg8), 32'(glyph[dv[4*d +: 4]]));
    end

    // Asynchronous reset mid-frame, checked before the next rising edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel2", 32'(sel2), 32'h3);
    chk("arst_sel8", 32'(sel8), 32'hFF);
    chk("arst_seg", 32'(seg2), 32'h7F);
    chk("arst_dp", 32'(dp2), 32'h1);
    chk("arst_page", 32'(page2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    chk("arst_dark", 32'(sel2), 32'h3);

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
